// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command stream into APB SETUP/ACCESS transfers
// and returns a held response. Optional ACCESS timeout via `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              pen,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              psel_nxt, pen_nxt, pwrite_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt;
    logic              rsp_valid_nxt, rsp_err_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] to_cnt;
    logic             to_hit;

    // Counts ACCESS cycles spent waiting on pready; restarted by every SETUP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if (state == ACCESS && !pready) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    assign cmd_ready = (state == IDLE);

    // State and all bus/response outputs are registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            psel      <= 1'b0;
            pen       <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            psel      <= psel_nxt;
            pen       <= pen_nxt;
            pwrite    <= pwrite_nxt;
            paddr     <= paddr_nxt;
            pwdata    <= pwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        psel_nxt      = psel;
        pen_nxt       = pen;
        pwrite_nxt    = pwrite;
        paddr_nxt     = paddr;
        pwdata_nxt    = pwdata;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt  = SETUP;
                    psel_nxt   = 1'b1;
                    pwrite_nxt = cmd_write;
                    paddr_nxt  = cmd_addr;
                    pwdata_nxt = cmd_wdata;
                end
            end
            SETUP: begin
                pen_nxt   = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                // pready wins over a timeout landing on the same edge
                if (pready) begin
                    state_nxt     = RESP;
                    psel_nxt      = 1'b0;
                    pen_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = pwrite ? '0 : prdata;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (to_hit) begin
                    state_nxt     = RESP;
                    psel_nxt      = 1'b0;
                    pen_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (initiator) for the existing APB slave; converts a simple valid/ready command stream into APB SETUP/ACCESS transfers.
- Returns read data, or a write completion, on a held response interface.
- Sits between the internal control logic (CPU-side sequencer or test driver) and the APB bus. Drives psel/pen/paddr/pwrite/pwdata; samples prdata/pready.

Parameters:
ADDR_W, 32, width of cmd_addr and paddr
DATA_W, 32, width of write/read data paths
TIMEOUT_CYCLES, 16, ACCESS-phase cycles allowed before abort (used only with the optional feature)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  block can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  transfer address
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  response available; held until rsp_ready
rsp_ready  input  1  response consumed
rsp_rdata  output  DATA_W  captured prdata for reads; 0 for writes
rsp_err  output  1  transfer aborted by timeout (always 0 without feature)
psel  output  1  APB select
pen  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_W  APB address
pwdata  output  DATA_W  APB write data
prdata  input  DATA_W  APB read data
pready  input  1  APB slave ready

Behaviour:
- Reset (async assert, sync release): state IDLE. psel=0, pen=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. cmd_ready=1 on the first edge after release.
- All APB and response outputs are registered. cmd_ready = (state==IDLE), decoded combinationally from the state register.
- FSM states:
  - IDLE: on cmd_valid&&cmd_ready at edge N, latch cmd_write/addr/wdata into pwrite/paddr/pwdata. psel=1, pen=0 -> SETUP. cmd_valid=0 stays in IDLE.
  - SETUP: exactly one cycle. Edge N+1: pen=1 -> ACCESS.
  - ACCESS: psel=1, pen=1 held while pready=0 (wait states, unbounded without the feature).
    - First edge with pready=1: psel=0, pen=0, rsp_valid=1, rsp_err=0.
    - rsp_rdata = prdata for a read; 0 for a write.
    - -> RESP.
  - RESP: rsp_valid held. On rsp_valid&&rsp_ready edge: rsp_valid=0 -> IDLE.
- Minimum latency: cmd accepted at edge N; rsp_valid visible after edge N+2 with zero wait states. Next command can be accepted at the edge after the response handshake. No back-to-back SETUP from ACCESS.
- paddr/pwrite/pwdata are stable from SETUP through the end of ACCESS. They keep their last values afterwards; they are not zeroed between transfers.
- pen is never 1 while psel=0. SETUP always precedes ACCESS.
- cmd_valid while cmd_ready=0 is ignored; the command is not captured, and the sender must hold it.
- rsp_ready while rsp_valid=0 has no effect.
- pready during SETUP is ignored.
- Reset mid-transfer: bus returns immediately to psel=0/pen=0; any pending response is discarded.
- No pslverr is supported. Read data is sampled only in the pready=1 ACCESS cycle.

Optional Feature:
- Macro APB_MASTER_TIMEOUT_EN.
- Defined:
  - Counter cleared on SETUP->ACCESS, incremented each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES-1 with pready still 0: psel=0, pen=0, rsp_valid=1, rsp_err=1, rsp_rdata=0 -> RESP.
  - pready=1 on that same edge takes priority: normal completion, rsp_err=0.
- Undefined: no counter logic is present, rsp_err is tied 0, and ACCESS waits indefinitely.

Test Plan:
1. Write: cmd_write=1, addr=0x4, wdata=0xDEADBEEF, pready=1 -> SETUP 1 cycle (psel=1, pen=0), ACCESS 1 cycle (pen=1, pwrite=1, paddr=0x4, pwdata=0xDEADBEEF), then rsp_valid=1, rsp_rdata=0.
2. Read with 3 wait states: addr=0x8, pready low 3 ACCESS cycles, prdata=0x12345678 on the 4th -> pen high 4 cycles, paddr stable, rsp_rdata=0x12345678.
3. Response backpressure: rsp_ready=0 for 5 cycles with cmd_valid=1 and a new command -> cmd_ready=0, psel stays 0, rsp_valid held; new transfer SETUP starts the cycle after the rsp_ready handshake.
4. Three writes (addr 0,1,2) then three reads (addr 0,1,2) against the APB slave model -> read data equals written data, in order.
5. Reset asserted during ACCESS (pready=0) -> psel=0, pen=0, rsp_valid=0 asynchronously; cmd_ready=1 after release.
6. (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16) pready held 0 -> exactly 16 ACCESS cycles, then rsp_valid=1, rsp_err=1, psel=0. Repeat with pready=1 on the 16th cycle -> rsp_err=0.
